// File: rtl/mem_rf.sv
// rtl/mem_rf.sv - byte-writable register-file memory with clear sweep, registered read and range error flag
module mem_rf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wen,
  input  logic [BE_W-1:0]   wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              busy,
  output logic              err
);

  // Index width that exactly addresses DEPTH entries; addr may be wider.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   next_cnt;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    cnt_idx;
  logic                in_range;
  logic                accept;
  logic                wr_fire;
  logic [DATA_W-1:0]   merged;

  assign idx      = addr[IDX_W-1:0];
  assign cnt_idx  = cnt[IDX_W-1:0];
  assign in_range = (32'(addr) < 32'(DEPTH));

  // Requests are honoured only in IDLE and never in the cycle that starts a clear.
  assign accept   = (state == IDLE) && !clr;
  assign wr_fire  = accept && wen && in_range;

  // Busy is simply the decoded state register, so it is high through reset and the whole sweep.
  assign busy     = (state == INIT);

  // Byte-merge of the addressed word with the write data; also feeds the write-first read path.
  always_comb begin
    merged = mem[idx];
    for (int k = 0; k < BE_W; k++) begin
      if (wbe[k]) begin
        merged[8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

  // Next-state logic: the sweep walks every entry once, a clear request restarts it.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      INIT: begin
        if (cnt == LAST) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt   = cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        next_cnt = '0;
        if (clr) begin
          next_state = INIT;
        end
      end
      default: begin
        next_state = INIT;
        next_cnt   = '0;
      end
    endcase
  end

  // State and sweep counter; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Storage array: no reset, cleared by the sweep; held still while reset is low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[cnt_idx] <= '0;
      end else if (wr_fire) begin
        mem[idx] <= merged;
      end
    end
  end

  // Registered read data, read-valid and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      if (accept) begin
        if (ren) begin
          rvalid <= 1'b1;
          if (!in_range) begin
            data_out <= '0;
          end else if (wen) begin
            data_out <= merged;
          end else begin
            data_out <= mem[idx];
          end
        end
        if ((ren || wen) && !in_range) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_rf.sv
// tb/tb_mem_rf.sv - scoreboard bench for mem_rf with directed vectors
module tb_mem_rf;

  logic        clk;
  logic        rst_n;
  logic [3:0]  addr;
  logic        wen;
  logic [1:0]  wbe;
  logic [15:0] wdata;
  logic        ren;
  logic        clr;
  logic [15:0] data_out;
  logic        rvalid;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int err_exp  = 0;
  int err_seen = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model [8];

  mem_rf #(.DATA_W(16), .DEPTH(8), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wen      (wen),
    .wbe      (wbe),
    .wdata    (wdata),
    .ren      (ren),
    .clr      (clr),
    .data_out (data_out),
    .rvalid   (rvalid),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] r;
    r = old;
    for (int k = 0; k < 2; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Monitor: every rvalid pops the next expected read word; err pulses are tallied.
  always begin
    @(posedge clk);
    #1;
    if (rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid actual=%h required=no_read", data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL read_data actual=%h required=%h", data_out, e);
        end
      end
    end
    if (err) err_seen++;
  end

  task automatic idle_inputs();
    wen = 1'b0; ren = 1'b0; clr = 1'b0; wbe = 2'b00; wdata = 16'h0; addr = 4'd0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    addr = a; wdata = d; wbe = be; wen = 1'b1; ren = 1'b0;
    if (a < 8) model[a[2:0]] = merge(model[a[2:0]], d, be);
    else err_exp++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] e);
    addr = a; ren = 1'b1; wen = 1'b0;
    exp_q.push_back(e);
    if (a >= 8) err_exp++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1);
    check("reset_rvalid", rvalid, 0);
    check("reset_err", err, 0);
    check("reset_data", data_out, 16'h0);

    // Sweep after release with a read held pending throughout.
    addr = 4'd3; ren = 1'b1;
    rst_n = 1'b1;
    wait_sweep("init_sweep_len");
    exp_q.push_back(16'h0000);
    @(negedge clk);
    idle_inputs();

    // Byte-enable merge.
    do_write(4'd2, 16'hABCD, 2'b11);
    do_write(4'd2, 16'h1234, 2'b01);
    do_read(4'd2, 16'hAB34);

    // Write-first on simultaneous read/write.
    addr = 4'd5; wdata = 16'h5A5A; wbe = 2'b11; wen = 1'b1; ren = 1'b1;
    model[5] = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    @(negedge clk);
    idle_inputs();
    do_write(4'd5, 16'h0000, 2'b00);
    do_read(4'd5, 16'h5A5A);
    do_write(4'd5, 16'hC300, 2'b10);
    do_read(4'd5, 16'hC35A);

    // Out-of-range accesses.
    do_write(4'd9, 16'hFFFF, 2'b11);
    do_read(4'd9, 16'h0000);
    do_read(4'd15, 16'h0000);
    for (int i = 0; i < 8; i++) do_read(4'(i), model[i]);
    @(negedge clk);
    check("err_count_oor", err_seen, 3);
    check("entry2_model", model[2], 16'hAB34);

    // Fill, then clear with a simultaneous write that must be dropped.
    for (int i = 0; i < 8; i++) do_write(4'(i), 16'h1111 * 16'(i + 1), 2'b11);
    for (int i = 0; i < 8; i++) do_read(4'(i), 16'h1111 * 16'(i + 1));
    clr = 1'b1; wen = 1'b1; addr = 4'd1; wdata = 16'hDEAD; wbe = 2'b11;
    @(negedge clk);
    idle_inputs();
    check("clr_data_hold", data_out, 16'h8888);
    wait_sweep("clr_sweep_len");
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    for (int i = 0; i < 8; i++) do_read(4'(i), 16'h0000);

    // Reset in the middle of a sweep.
    do_write(4'd3, 16'h7777, 2'b11);
    do_read(4'd3, 16'h7777);
    clr = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("mid_sweep_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_data", data_out, 16'h0);
    check("async_reset_busy", busy, 1);
    repeat (2) @(negedge clk);
    check("held_reset_busy", busy, 1);
    rst_n = 1'b1;
    wait_sweep("restart_sweep_len");
    do_read(4'd3, 16'h0000);
    do_read(4'd0, 16'h0000);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("err_count_total", err_seen, err_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_rf.md
MEM_RF -- requirements
Module: mem_rf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 8: number of words, 2..256.
REQ-003 The block SHALL have parameter ADDR_W, default 4: address width, with 2^ADDR_W >= DEPTH.
REQ-004 The block SHALL have derived parameter BE_W = DATA_W/8: byte-enable width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port addr, input, ADDR_W bits: shared read/write word address.
REQ-008 The block SHALL have port wen, input, 1 bit: write request.
REQ-009 The block SHALL have port wbe, input, BE_W bits: byte enables; bit k covers wdata[8k+7:8k].
REQ-010 The block SHALL have port wdata, input, DATA_W bits: write data.
REQ-011 The block SHALL have port ren, input, 1 bit: read request.
REQ-012 The block SHALL have port clr, input, 1 bit: request a full memory clear.
REQ-013 The block SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-014 The block SHALL have port rvalid, output, 1 bit: single-cycle pulse marking data_out as updated by a read.
REQ-015 The block SHALL have port busy, output, 1 bit: clear sweep in progress; requests are ignored while high.
REQ-016 The block SHALL have port err, output, 1 bit: single-cycle pulse flagging an out-of-range access.

Function
REQ-017 The FSM SHALL have two states, INIT (clear sweep) and IDLE, with a sweep counter of ADDR_W bits.
REQ-018 INIT SHALL write all-zero to entry cnt each cycle and increment cnt; after writing entry DEPTH-1 it SHALL go to IDLE with cnt=0.
REQ-019 busy SHALL be 1 exactly while the state is INIT (registered, DEPTH cycles per sweep).
REQ-020 In INIT, wen/ren/clr SHALL be ignored: no write, rvalid=0, err=0, and data_out holds.
REQ-021 In IDLE, clr=1 SHALL enter INIT at the next edge, and all wen/ren in that cycle SHALL be dropped.
REQ-022 In IDLE, a write with wen=1 and addr<DEPTH SHALL update only the bytes with wbe[k]=1 at the edge; wbe=0 leaves the entry unchanged.
REQ-023 In IDLE, ren=1 with addr<DEPTH SHALL load data_out with mem[addr] at the edge and set rvalid=1 for that one cycle (latency 1).
REQ-024 When ren=1 and wen=1 hit the same in-range addr in one cycle, the read SHALL be write-first: data_out equals the byte-merged new word.
REQ-025 data_out SHALL hold its last value whenever no read completes; the design SHALL infer no latch.
REQ-026 An IDLE access with addr>=DEPTH SHALL drop the write and pulse err=1 for one cycle; if ren=1, data_out SHALL become 0 with rvalid=1.
REQ-027 rvalid and err SHALL be registered and return to 0 the cycle after a pulse unless re-triggered.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=INIT, cnt=0, data_out=0, rvalid=0, err=0 and busy=1.
REQ-029 Memory contents SHALL NOT be reset directly; they are zeroed by the INIT sweep starting at the first edge after rst_n rises.
REQ-030 Reset asserted mid-sweep or mid-access SHALL abort the operation and restart the sweep from entry 0.

Verification (DATA_W=16, DEPTH=8, ADDR_W=4)
REQ-031 Release rst_n, hold ren=1 addr=3 -> busy=1 for 8 cycles and rvalid=0 throughout; first IDLE read of addr 3 gives rvalid=1, data_out=0x0000.
REQ-032 Write addr=2 wdata=0xABCD wbe=11, then addr=2 wdata=0x1234 wbe=01, then read addr=2 -> data_out=0xAB34 one cycle after ren.
REQ-033 In one cycle wen=1 ren=1 addr=5 wdata=0x5A5A wbe=11 -> next cycle data_out=0x5A5A, rvalid=1.
REQ-034 Write addr=9 wdata=0xFFFF, then read addr=9 -> err pulses on both accesses, no entry changes, data_out=0x0000 with rvalid=1.
REQ-035 Fill entries 0..7 with non-zero data, pulse clr together with wen addr=1 -> the write is dropped, busy=1 for 8 cycles, then all reads return 0x0000.
REQ-036 Assert rst_n=0 at the 4th sweep cycle -> busy stays 1, and after release the sweep restarts with busy=1 for a full 8 cycles.
